// File: rtl/power3_result_buffer.sv
// Result buffer behind the free-running cube pipeline: tags accepted samples, captures their
// results into a first-word-fall-through FIFO and issues credits so no result is ever lost.
module power3_result_buffer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [WIDTH-1:0]         i_xPower,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_dropped
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  // Occupancy plus in-flight results can exceed DEPTH, so the sum gets one extra bit.
  localparam int unsigned SW = CW + 1;

  if (LATENCY < 1) begin : g_bad_latency
    $error("power3_result_buffer: LATENCY must be at least 1");
  end
  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth_pow2
    $error("power3_result_buffer: DEPTH must be a power of two");
  end
  if (DEPTH < LATENCY + 1) begin : g_bad_depth_min
    $error("power3_result_buffer: DEPTH must be at least LATENCY+1");
  end

  logic [LATENCY-1:0] tag_q, tag_d;
  logic [CW-1:0]      count_q, count_d;
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               dropped_q;

  logic               accept;
  logic               wr_en;
  logic               rd_en;
  logic [SW-1:0]      inflight;
  logic [SW-1:0]      occupancy;

  // Credits come from registered state only; a pop this cycle is not counted until next cycle.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < int'(LATENCY); k++) begin
      inflight = inflight + SW'(tag_q[k]);
    end
    occupancy = SW'(count_q) + inflight;
    o_ready   = (occupancy < SW'(DEPTH));
  end

  always_comb begin
    accept  = i_valid & o_ready;
    wr_en   = tag_q[LATENCY-1];
    o_valid = (count_q != '0);
    rd_en   = o_valid & i_ready;
    count_d = count_q + CW'(wr_en) - CW'(rd_en);
  end

  always_comb begin
    tag_d    = '0;
    tag_d[0] = accept;
    for (int k = 1; k < int'(LATENCY); k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      tag_q     <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      dropped_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      count_q <= count_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      // A sample offered without credit is neither tagged nor stored; remember it until reset.
      if (i_valid && !o_ready) begin
        dropped_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only observed once the count covers them.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= i_xPower;
    end
  end

  always_comb begin
    o_data    = mem_q[rd_ptr_q];
    o_count   = count_q;
    o_dropped = dropped_q;
  end

endmodule

// File: doc/power3_result_buffer.md
Name: power3_result_buffer

Overview:
Downstream companion to the free-running 8-bit cube pipeline (x^3, fixed 3-cycle latency, no valid/stall). It tracks which pipeline slots carry real samples, captures the cube results into a small FWFT FIFO, and presents them on a ready/valid output interface. Because the cube pipeline cannot stall, the block issues upstream credits so that no result is ever lost.

Parameters:
WIDTH, 8, data width; must equal the cube pipeline width.
LATENCY, 3, cube pipeline latency in cycles (i_x in cycle t -> result on i_xPower in cycle t+LATENCY); legal values >= 1.
DEPTH, 8, FIFO entries; power of two; must be >= LATENCY+1; full throughput requires >= LATENCY+2.

Ports:
i_clk  in  1  clock, rising edge.
i_arst_n  in  1  asynchronous, active-low reset.
i_valid  in  1  source drives a real sample onto the cube pipeline input this cycle.
o_ready  out  1  credit available; a sample is accepted when i_valid & o_ready.
i_xPower  in  WIDTH  cube pipeline output.
o_data  out  WIDTH  head-of-FIFO result (x^3 mod 2^WIDTH).
o_valid  out  1  FIFO not empty.
i_ready  in  1  consumer accepts o_data; pop occurs when o_valid & i_ready.
o_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
o_dropped  out  1  sticky protocol-violation flag.

Behaviour:
- Reset is asynchronous and active-low: clock is i_clk, reset is i_arst_n. While asserted, all in-flight tags, pointers and the count are cleared. Outputs under reset: o_valid=0, o_count=0, o_dropped=0, o_ready=1; o_data is don't-care.
- accept = i_valid & o_ready. A LATENCY-bit tag shift register tracks accepted samples: tag[0] <= accept; tag[k] <= tag[k-1].
- FIFO write: occurs when tag[LATENCY-1] is 1, writing i_xPower in that same cycle. This aligns exactly with the result of the sample accepted LATENCY cycles earlier.
- Credit: inflight = popcount(tag). o_ready = (count + inflight) < DEPTH.
  - o_ready is a function of registers only; there is no combinational path from i_ready.
  - A pop in the current cycle is not credited.
- FIFO is first-word-fall-through:
  - o_valid = (count != 0); o_data = mem[rd_ptr].
  - Pointers wrap modulo DEPTH.
  - Count update: count += wr - rd.
- Latency: a sample accepted in cycle t is written in cycle t+LATENCY. o_valid for it is high no earlier than cycle t+LATENCY+1 (t+4 with defaults).
- Simultaneous write and pop: both happen, and count is unchanged. Write into a full FIFO is impossible by construction. A pop while empty is ignored, because o_valid=0.
- Empty FIFO with a write in the same cycle: o_valid stays 0 that cycle and rises the next cycle. There is no bypass.
- Violation: i_valid=1 while o_ready=0 means the sample is not tagged and is not stored. o_dropped is set the next cycle and stays set until reset.
- Reset mid-operation: all in-flight and buffered results are discarded. The cube pipeline itself is not reset; its stale outputs are ignored because all tags are cleared. The first sample accepted after release behaves normally.
- Elaboration check: an error is raised if DEPTH is not a power of two, DEPTH < LATENCY+1, or LATENCY < 1.
- Defaults: sustained 1 sample/cycle when i_ready is held high, because count + inflight <= 4 < 8.

Test Plan:
1. Reset: assert i_arst_n=0 mid-clock -> immediately o_valid=0, o_count=0, o_dropped=0, o_ready=1.
2. Streaming: i_valid=1 for cycles 0..9 with x=0..9, i_ready=1 -> o_valid high from cycle 4. o_data sequence 0,1,8,27,64,125,216,87,0,217. o_ready never drops; o_dropped=0.
3. Backpressure: i_ready=0, source honours o_ready, x=2 continuous -> o_ready falls after 8 accepts. o_count reaches 8 with all entries 8; no loss. Then i_ready=1 -> 8 pops of value 8, and o_ready reasserts the cycle after count+inflight<8.
4. Violation: with FIFO full, pulse i_valid=1 once with x=3 -> no entry of 27 appears, o_count stays 8, o_dropped=1. o_dropped stays 1 after draining, until reset.
5. Reset in flight: accept x=4,5,6 on cycles 0..2, assert reset in cycle 3 for 1 cycle -> no o_valid ever for 64/125/216. o_count=0, and a new x=7 afterward yields 87 after 4 cycles.
6. Wrap: 20 samples x=255 with i_ready toggling every cycle -> every output is 255. Pointers wrap past DEPTH with no duplicates or losses (exactly 20 pops).
